// File: rtl/des_key_sched.sv
// DES key schedule: registered K1..K16 (or K16..K1 for decrypt), first subkey 1 cycle after key_load.
// Valid/ready handshake; subkey, rnd and C/D hold while subkey_ready is low.
module des_key_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_load,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  rnd,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  // Table entries are FIPS bit numbers; FIPS bit n of the key is key[64-n].
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit i set when round i+1 rotates by two positions.
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TBL[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TBL[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state, state_nxt;
  logic [27:0] c, d, c_nxt, d_nxt;
  logic        dir, dir_nxt;
  logic [3:0]  rnd_nxt, rnd_inc;
  logic [47:0] subkey_nxt;
  logic        valid_nxt, busy_nxt, done_nxt;
  logic        accept;
  logic [55:0] cd0;

  // Parity bits take no part in the schedule.
  logic unused_parity;
  assign unused_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};

  assign accept  = subkey_valid & subkey_ready;
  assign cd0     = pc1(key);
  assign rnd_inc = rnd + 4'd1;

  always_comb begin
    state_nxt  = state;
    c_nxt      = c;
    d_nxt      = d;
    dir_nxt    = dir;
    rnd_nxt    = rnd;
    subkey_nxt = subkey;
    valid_nxt  = subkey_valid;
    done_nxt   = 1'b0;

    if (key_load) begin
      state_nxt = RUN;
      dir_nxt   = decrypt;
      rnd_nxt   = 4'd0;
      valid_nxt = 1'b1;
      // Decrypt starts at K16, whose total rotation of 28 leaves C0/D0 unchanged.
      if (decrypt) begin
        c_nxt = cd0[55:28];
        d_nxt = cd0[27:0];
      end else begin
        c_nxt = rotl(cd0[55:28], 1'b0);
        d_nxt = rotl(cd0[27:0], 1'b0);
      end
      subkey_nxt = pc2({c_nxt, d_nxt});
    end else if (state == RUN && accept) begin
      if (rnd == 4'd15) begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        done_nxt  = 1'b1;
      end else begin
        rnd_nxt = rnd_inc;
        // Walking backwards undoes the shift of the round currently presented.
        if (dir) begin
          c_nxt = rotr(c, SHIFT2[4'd15 - rnd]);
          d_nxt = rotr(d, SHIFT2[4'd15 - rnd]);
        end else begin
          c_nxt = rotl(c, SHIFT2[rnd_inc]);
          d_nxt = rotl(d, SHIFT2[rnd_inc]);
        end
        subkey_nxt = pc2({c_nxt, d_nxt});
      end
    end

    busy_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      c            <= '0;
      d            <= '0;
      dir          <= 1'b0;
      rnd          <= '0;
      subkey       <= '0;
      subkey_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      c            <= c_nxt;
      d            <= d_nxt;
      dir          <= dir_nxt;
      rnd          <= rnd_nxt;
      subkey       <= subkey_nxt;
      subkey_valid <= valid_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

endmodule

// File: tb/tb_des_key_sched.sv
// Bench for des_key_sched: directed runs with a queue-based scoreboard checked on the falling edge.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_load = 1'b0;
  logic [63:0] key = '0;
  logic        decrypt = 1'b0;
  logic        subkey_ready = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  rnd;
  logic        busy;
  logic        done;

  des_key_sched dut (
    .clk          (clk),
    .reset        (reset),
    .key_load     (key_load),
    .key          (key),
    .decrypt      (decrypt),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .rnd          (rnd),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123457799BBCDFF0;
  localparam logic [63:0] KEY_W = 64'hFFFFFFFFFFFFFFFF;

  // Published K1..K16 for KEY_A.
  logic [47:0] ka [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  r;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   d0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: peeks the queue head every valid cycle, pops on accept.
  logic        exp_done = 1'b0;
  logic [47:0] last_sk = '0;
  always @(negedge clk) begin
    exp_t e;
    if (exp_done) begin
      check("done_pulse", 64'(done), 64'd1);
      check("valid_after_last", 64'(subkey_valid), 64'd0);
      check("busy_after_last", 64'(busy), 64'd0);
      check("subkey_hold_after_last", 64'(subkey), 64'(last_sk));
      exp_done = 1'b0;
    end else if (done) begin
      check("spurious_done", 64'(done), 64'd0);
    end
    if (done) done_cnt++;
    if (subkey_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(subkey_valid), 64'd0);
      end else begin
        e = exp_q[0];
        check("subkey", 64'(subkey), 64'(e.sk));
        check("rnd", 64'(rnd), 64'(e.r));
        check("busy_run", 64'(busy), 64'd1);
        if (subkey_ready) begin
          void'(exp_q.pop_front());
          if (e.last && !key_load && reset) begin
            exp_done = 1'b1;
            last_sk  = e.sk;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [63:0] k, input logic dec);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      if (k == KEY_W) e.sk = 48'hFFFFFFFFFFFF;
      else            e.sk = dec ? ka[15-i] : ka[i];
      e.r    = 4'(i);
      e.last = (i == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic load(input logic [63:0] k, input logic dec);
    key      = k;
    decrypt  = dec;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    exp_q.delete();
    push_run(k, dec);
  endtask

  task automatic drain(input int budget, input bit rand_rdy);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      subkey_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    subkey_ready = 1'b1;
  endtask

  task automatic wait_size(input int n, input int budget);
    subkey_ready = 1'b1;
    for (int c = 0; c < budget && exp_q.size() != n; c++) tick();
    if (exp_q.size() != n) check("wait_timeout", 64'(exp_q.size()), 64'(n));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_subkey"}, 64'(subkey), 64'd0);
    check({tag, "_valid"}, 64'(subkey_valid), 64'd0);
    check({tag, "_rnd"}, 64'(rnd), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check_idle("reset");
    reset = 1'b1;
    repeat (4) tick();
    check_idle("post_reset_hold");

    // Encrypt with ready held high.
    d0 = done_cnt;
    load(KEY_A, 1'b0);
    drain(100, 1'b0);
    tick(); tick();
    check("done_count_enc", 64'(done_cnt - d0), 64'd1);

    // Decrypt: reversed sequence.
    d0 = done_cnt;
    load(KEY_A, 1'b1);
    drain(100, 1'b0);
    tick(); tick();
    check("done_count_dec", 64'(done_cnt - d0), 64'd1);

    // Parity-flipped key under random back-pressure must yield the same subkeys.
    d0 = done_cnt;
    load(KEY_P, 1'b0);
    drain(400, 1'b1);
    tick(); tick();
    check("done_count_parity", 64'(done_cnt - d0), 64'd1);

    // New key at rnd 7 aborts without done.
    d0 = done_cnt;
    load(KEY_A, 1'b0);
    wait_size(9, 50);
    check("abort_point_rnd", 64'(rnd), 64'd7);
    load(KEY_W, 1'b0);
    drain(100, 1'b0);
    tick(); tick();
    check("done_count_abort", 64'(done_cnt - d0), 64'd1);

    // key_load together with the final accept: restart wins, no done.
    d0 = done_cnt;
    load(KEY_A, 1'b1);
    wait_size(1, 50);
    check("last_point_rnd", 64'(rnd), 64'd15);
    load(KEY_A, 1'b0);
    drain(100, 1'b0);
    tick(); tick();
    check("done_count_last_restart", 64'(done_cnt - d0), 64'd1);

    // Reset at rnd 5 aborts; next load starts cleanly.
    d0 = done_cnt;
    load(KEY_A, 1'b0);
    wait_size(11, 50);
    subkey_ready = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    check_idle("reset_mid_run");
    tick(); tick();
    check("done_count_reset", 64'(done_cnt - d0), 64'd0);
    check_idle("reset_mid_run_hold");
    d0 = done_cnt;
    load(KEY_A, 1'b1);
    drain(100, 1'b0);
    tick(); tick();
    check("done_count_after_reset", 64'(done_cnt - d0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/des_key_sched.md
DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on posedge clk.
REQ-002 SHALL: reset  input  1  reset, synchronous, active-low (reset==0 at posedge clears state).
REQ-003 SHALL: key_load  input  1  one-cycle strobe to capture key and decrypt, then start a schedule.
REQ-004 SHALL: key  input  64  DES key; key[63] is FIPS 46-3 bit 1; parity bits (FIPS bits 8,16,...,64) ignored.
REQ-005 SHALL: decrypt  input  1  0 = deliver K1..K16; 1 = deliver K16..K1.
REQ-006 SHALL: subkey_ready  input  1  consumer (E-expansion XOR feeding the S-box stage) accepts subkey this cycle.
REQ-007 SHALL: subkey  output  48  current round subkey; bit 47 is PC-2 output bit 1.
REQ-008 SHALL: subkey_valid  output  1  subkey, rnd are valid.
REQ-009 SHALL: rnd  output  4  sequence position of current subkey, 0..15.
REQ-010 SHALL: busy  output  1  schedule in progress (state RUN).
REQ-011 SHALL: done  output  1  one-cycle pulse after 16th subkey accepted.

Function
REQ-012 SHALL: states IDLE, RUN; state, C/D registers (28 bit each), round counter, direction flag and all outputs registered.
REQ-013 SHALL: key_load in any state -> next cycle: C,D = PC-1(key) adjusted as REQ-015/016, direction latched from decrypt, rnd=0, subkey_valid=1, busy=1, state RUN.
REQ-014 SHALL: first subkey valid exactly 1 cycle after key_load (latency 1); no combinational path key->subkey.
REQ-015 SHALL: encrypt: shift table S = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}; Ki = PC-2(Ci,Di), Ci/Di = Ci-1/Di-1 rotated left by S[i]; first output K1 = PC-2(C0<<<1, D0<<<1).
REQ-016 SHALL: decrypt: first output K16 = PC-2(C0,D0) (total rotation 28); Ki-1 from Ki by rotating C,D right by S[i].
REQ-017 SHALL: accept = subkey_valid & subkey_ready; on accept with rnd<15: advance C/D, rnd+1, subkey updated next cycle, subkey_valid stays 1.
REQ-018 SHALL: no accept -> subkey, rnd, C/D held stable (back-pressure, any number of cycles).
REQ-019 SHALL: accept with rnd==15 -> next cycle state IDLE, subkey_valid=0, busy=0, done=1 for exactly one cycle; subkey holds last value.
REQ-020 SHALL: key_load simultaneous with accept (any rnd, incl. 15) -> key_load wins: restart per REQ-013, no done pulse.
REQ-021 SHALL: key_load during RUN aborts current schedule without done.
REQ-022 SHALL: subkey_ready ignored when subkey_valid==0; rnd wraps never (only 0..15 reachable).
REQ-023 SHALL: PC-1, PC-2 exactly per FIPS 46-3 tables; pure bit selection, no arithmetic.

Reset
REQ-024 SHALL: reset==0 -> next cycle state IDLE, subkey=48'h0, subkey_valid=0, rnd=0, busy=0, done=0, C=D=28'h0.
REQ-025 SHALL: reset has priority over key_load and accept; reset mid-RUN aborts with no done pulse.
REQ-026 SHALL: after reset released, no output change until key_load.

Verification
REQ-027 SHALL: key=64'h133457799BBCDFF1, decrypt=0, ready=1 -> cycle+1 subkey=48'h1B02EFFC7072 rnd=0; 16th subkey=48'hCB3D8B0E17F5 rnd=15; done one cycle later.
REQ-028 SHALL: same key, decrypt=1 -> first subkey 48'hCB3D8B0E17F5, last 48'h1B02EFFC7072; full sequence equals encrypt sequence reversed.
REQ-029 SHALL: ready toggled randomly -> subkey/rnd stable while ready=0; exactly 16 accepts then done; sequence matches golden model.
REQ-030 SHALL: key_load asserted at rnd=7 with new key -> next cycle rnd=0, subkey=K1 of new key, no done pulse.
REQ-031 SHALL: reset=0 at rnd=5 -> next cycle all outputs zero, IDLE; subsequent key_load starts cleanly at rnd=0.
REQ-032 SHALL: flip only parity bits of key (e.g. 64'h123457799BBCDFF0 vs 64'h133457799BBCDFF1) -> identical 16-subkey sequence.
